fe_fb_array: RTL and testbench

Multi-entry fetch buffer between the front-end PC generator and the instruction cache. It holds up to NUM_FB outstanding line fetches, either demand fetches or prefetches. IC requests from pending entries are arbitrated round-robin and IC responses are matched by entry id, so they may return out of order. Demand instructions go back to the FE strictly in push order. Prefetch entries retire silently. A flush drops outstanding work.

---
 rtl/fe_fb_array.sv | 221 ++++++++++++++++++++++
 tb/tb_fe_fb_array.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_fb_array.sv
// fe_fb_array: multi-entry fetch buffer between the PC generator and the I$.
// Holds up to NUM_FB line fetches (demand or prefetch). Pending IC requests
// are picked round-robin, IC responses return by entry id in any order, and
// demand instructions return to the FE strictly in push order.
// Ports:
//   clk, reset          clock, async active-high reset
//   push_*              allocate a fetch (addr, prefetch flag); push_ready = free entry
//   ic_req_*            line request to the I$ (addr, entry id); ic_req_ready = grant
//   ic_rsp_*            I$ line response targeting entry ic_rsp_id
//   fe_rsp_*            in-order instruction return to the FE
//   flush               drop all outstanding work
//   occupancy           number of non-IDLE entries
module fe_fb_array #(
   parameter int NUM_FB   = 4,
   parameter int ADDR_W   = 32,
   parameter int CL_BYTES = 64,
   parameter int INSTR_W  = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push_valid,
   input  logic [ADDR_W-1:0]         push_addr,
   input  logic                      push_pf,
   output logic                      push_ready,
   output logic                      ic_req_valid,
   output logic [ADDR_W-1:0]         ic_req_addr,
   output logic [$clog2(NUM_FB)-1:0] ic_req_id,
   input  logic                      ic_req_ready,
   input  logic                      ic_rsp_valid,
   input  logic [$clog2(NUM_FB)-1:0] ic_rsp_id,
   input  logic [CL_BYTES*8-1:0]     ic_rsp_data,
   output logic                      fe_rsp_valid,
   output logic [ADDR_W-1:0]         fe_rsp_pc,
   output logic [INSTR_W-1:0]        fe_rsp_instr,
   input  logic                      fe_rsp_ready,
   input  logic                      flush,
   output logic [$clog2(NUM_FB):0]   occupancy
);

   localparam int IDW = $clog2(NUM_FB);
   localparam int OFW = $clog2(CL_BYTES);
   localparam int IBW = $clog2(INSTR_W/8);
   localparam int WDW = OFW - IBW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_IC,
      S_PDG_IC,
      S_REQ_FE,
      S_FLUSHED
   } state_t;

   state_t             r_state  [NUM_FB];
   state_t             w_nstate [NUM_FB];
   logic [ADDR_W-1:0]  r_addr   [NUM_FB];
   logic [INSTR_W-1:0] r_instr  [NUM_FB];
   logic [NUM_FB-1:0]  r_pf;
   // r_age[i][j] = 1 : entry j is older than entry i
   logic [NUM_FB-1:0]  r_age    [NUM_FB];
   logic [IDW-1:0]     r_rr;

   logic [NUM_FB-1:0]  w_idle;
   logic [NUM_FB-1:0]  w_valid;
   logic [NUM_FB-1:0]  w_req;
   logic [NUM_FB-1:0]  w_cand;
   logic [IDW-1:0]     w_alloc_id;
   logic               w_push;
   logic [IDW-1:0]     w_idx;
   logic [IDW-1:0]     w_sel_id;
   logic               w_sel_hit;
   logic               w_grant;
   logic [IDW-1:0]     w_fe_id;
   logic               w_fe_hit;
   logic               w_fe_fire;
   logic [WDW-1:0]     w_rsp_word;
   logic [INSTR_W-1:0] w_rsp_instr;
   logic [IDW:0]       w_occ;

   always_comb begin
      w_idle  = '0;
      w_req   = '0;
      w_cand  = '0;
      for (int i = 0; i < NUM_FB; i++) begin
         w_idle[i] = (r_state[i] == S_IDLE);
         w_req[i]  = (r_state[i] == S_REQ_IC);
         // demand entries still owed to the FE, in any stage
         w_cand[i] = ~r_pf[i] & ((r_state[i] == S_REQ_IC) |
                                 (r_state[i] == S_PDG_IC) |
                                 (r_state[i] == S_REQ_FE));
      end
      w_valid = ~w_idle;
   end

   // lowest-index free entry
   always_comb begin
      w_alloc_id = '0;
      for (int i = NUM_FB-1; i >= 0; i--) begin
         if (w_idle[i]) w_alloc_id = IDW'(i);
      end
   end

   assign push_ready = |w_idle;
   assign w_push     = push_valid & push_ready & ~flush;

   // round-robin: first REQ_IC entry at or after r_rr, wrapping
   always_comb begin
      w_sel_id  = '0;
      w_sel_hit = 1'b0;
      w_idx     = '0;
      for (int k = 0; k < NUM_FB; k++) begin
         w_idx = r_rr + IDW'(k);
         if (!w_sel_hit && w_req[w_idx]) begin
            w_sel_id  = w_idx;
            w_sel_hit = 1'b1;
         end
      end
   end

   assign ic_req_valid = |w_req;
   assign ic_req_id    = w_sel_id;
   assign ic_req_addr  = ic_req_valid ?
                         {r_addr[w_sel_id][ADDR_W-1:OFW], {OFW{1'b0}}} :
                         '0;
   assign w_grant      = ic_req_valid & ic_req_ready;

   // oldest outstanding demand entry: no other candidate is older
   always_comb begin
      w_fe_id  = '0;
      w_fe_hit = 1'b0;
      for (int i = 0; i < NUM_FB; i++) begin
         if (w_cand[i] && ((r_age[i] & w_cand) == '0)) begin
            w_fe_id  = IDW'(i);
            w_fe_hit = 1'b1;
         end
      end
   end

   assign fe_rsp_valid = w_fe_hit & (r_state[w_fe_id] == S_REQ_FE) & ~flush;
   assign fe_rsp_pc    = fe_rsp_valid ? r_addr[w_fe_id]  : '0;
   assign fe_rsp_instr = fe_rsp_valid ? r_instr[w_fe_id] : '0;
   assign w_fe_fire    = fe_rsp_valid & fe_rsp_ready;

   assign w_rsp_word  = r_addr[ic_rsp_id][OFW-1:IBW];
   assign w_rsp_instr = ic_rsp_data[w_rsp_word*INSTR_W +: INSTR_W];

   always_comb begin
      for (int i = 0; i < NUM_FB; i++) begin
         w_nstate[i] = r_state[i];
         unique case (r_state[i])
            S_IDLE: begin
               if (w_push && w_alloc_id == IDW'(i))
                  w_nstate[i] = S_REQ_IC;
            end
            S_REQ_IC: begin
               if (w_grant && w_sel_id == IDW'(i))
                  w_nstate[i] = flush ? S_FLUSHED : S_PDG_IC;
               else if (flush)
                  w_nstate[i] = S_IDLE;
            end
            S_PDG_IC: begin
               // a response arriving with flush completes the fetch outright
               if (ic_rsp_valid && ic_rsp_id == IDW'(i))
                  w_nstate[i] = (r_pf[i] | flush) ? S_IDLE : S_REQ_FE;
               else if (flush)
                  w_nstate[i] = S_FLUSHED;
            end
            S_REQ_FE: begin
               if (flush || (w_fe_fire && w_fe_id == IDW'(i)))
                  w_nstate[i] = S_IDLE;
            end
            S_FLUSHED: begin
               if (ic_rsp_valid && ic_rsp_id == IDW'(i))
                  w_nstate[i] = S_IDLE;
            end
            default: w_nstate[i] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_FB; i++) begin
            r_state[i] <= S_IDLE;
            r_addr[i]  <= '0;
            r_instr[i] <= '0;
            r_age[i]   <= '0;
         end
         r_pf <= '0;
         r_rr <= '0;
      end else begin
         for (int i = 0; i < NUM_FB; i++) r_state[i] <= w_nstate[i];
         if (w_grant) r_rr <= w_sel_id + 1'b1;
         if (w_push) begin
            r_addr[w_alloc_id] <= push_addr;
            r_pf[w_alloc_id]   <= push_pf;
            for (int j = 0; j < NUM_FB; j++) r_age[j][w_alloc_id] <= 1'b0;
            r_age[w_alloc_id] <= w_valid;
         end
         if (ic_rsp_valid && r_state[ic_rsp_id] == S_PDG_IC)
            r_instr[ic_rsp_id] <= w_rsp_instr;
      end
   end

   always_comb begin
      w_occ = '0;
      for (int i = 0; i < NUM_FB; i++)
         w_occ = w_occ + {{IDW{1'b0}}, w_valid[i]};
   end

   assign occupancy = w_occ;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && ic_rsp_valid)
         assert (r_state[ic_rsp_id] == S_PDG_IC ||
                 r_state[ic_rsp_id] == S_FLUSHED)
         else $error("fe_fb_array: response to inactive entry %0d", ic_rsp_id);
   end
`endif

endmodule

// File: tb/tb_fe_fb_array.sv
// tb_fe_fb_array: directed vectors, corner sequences and a randomized run
// against a queue-based reference model of the fetch buffer.
module tb_fe_fb_array;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         push_valid;
   logic [31:0]  push_addr;
   logic         push_pf;
   logic         push_ready;
   logic         ic_req_valid;
   logic [31:0]  ic_req_addr;
   logic [1:0]   ic_req_id;
   logic         ic_req_ready;
   logic         ic_rsp_valid;
   logic [1:0]   ic_rsp_id;
   logic [511:0] ic_rsp_data;
   logic         fe_rsp_valid;
   logic [31:0]  fe_rsp_pc;
   logic [31:0]  fe_rsp_instr;
   logic         fe_rsp_ready;
   logic         flush;
   logic [2:0]   occupancy;

   fe_fb_array dut (
      .clk(clk), .reset(reset),
      .push_valid(push_valid), .push_addr(push_addr),
      .push_pf(push_pf), .push_ready(push_ready),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
      .ic_req_id(ic_req_id), .ic_req_ready(ic_req_ready),
      .ic_rsp_valid(ic_rsp_valid), .ic_rsp_id(ic_rsp_id),
      .ic_rsp_data(ic_rsp_data),
      .fe_rsp_valid(fe_rsp_valid), .fe_rsp_pc(fe_rsp_pc),
      .fe_rsp_instr(fe_rsp_instr), .fe_rsp_ready(fe_rsp_ready),
      .flush(flush), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      bit          pf;
      logic [31:0] e_req;
      bit          e_fv;
      logic [31:0] e_instr;
   } vec_t;

   vec_t tbl [6];

   // reference model state
   bit          m_used [N];
   bit          m_gnt  [N];
   bit          m_rsp  [N];
   bit          m_fl   [N];
   bit          m_pf   [N];
   logic [31:0] m_addr [N];
   logic [31:0] m_instr[N];
   int          m_rr;
   int          dq[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      push_valid   = 1'b0;
      push_addr    = '0;
      push_pf      = 1'b0;
      ic_req_ready = 1'b0;
      ic_rsp_valid = 1'b0;
      ic_rsp_id    = '0;
      ic_rsp_data  = '0;
      fe_rsp_ready = 1'b0;
      flush        = 1'b0;
   endtask

   task automatic do_reset();
      idle_in();
      reset = 1'b1;
      #12;
      reset = 1'b0;
      tick();
   endtask

   function automatic logic [511:0] mkline(input logic [31:0] base);
      logic [511:0] l;
      for (int k = 0; k < 16; k++) l[k*32 +: 32] = base | 32'(k);
      return l;
   endfunction

   task automatic send(input int id, input logic [511:0] l);
      ic_rsp_valid = 1'b1;
      ic_rsp_id    = 2'(id);
      ic_rsp_data  = l;
      tick();
      ic_rsp_valid = 1'b0;
   endtask

   task automatic push(input logic [31:0] a, input bit pf);
      push_valid = 1'b1;
      push_addr  = a;
      push_pf    = pf;
      tick();
      push_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [511:0] l;
      logic [31:0]  pc0;
      logic [31:0]  in0;
      int           rid;
      int           e_alloc;
      bit           e_pr;
      int           e_occ;
      bit           e_rv;
      int           e_rid;
      bit           e_fv;
      int           pend[$];

      tbl[0] = '{32'h0000_1008, 1'b0, 32'h0000_1000, 1'b1, 32'hA000_0002};
      tbl[1] = '{32'h0000_203C, 1'b0, 32'h0000_2000, 1'b1, 32'hA000_000F};
      tbl[2] = '{32'h0000_7FC0, 1'b0, 32'h0000_7FC0, 1'b1, 32'hA000_0000};
      tbl[3] = '{32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFC0, 1'b1, 32'hA000_000F};
      tbl[4] = '{32'h1234_5674, 1'b0, 32'h1234_5640, 1'b1, 32'hA000_000D};
      tbl[5] = '{32'h0000_2000, 1'b1, 32'h0000_2000, 1'b0, 32'h0};

      // reset state, checked while reset is held
      idle_in();
      reset = 1'b1;
      #3;
      chk("rst_push_ready", push_ready, 1);
      chk("rst_req_valid", ic_req_valid, 0);
      chk("rst_req_addr", ic_req_addr, 0);
      chk("rst_fe_valid", fe_rsp_valid, 0);
      chk("rst_occ", occupancy, 0);
      do_reset();

      // basic demand fetch
      ic_req_ready = 1'b1;
      push(32'h1008, 1'b0);
      #1;
      chk("t1_req_valid", ic_req_valid, 1);
      chk("t1_req_addr", ic_req_addr, 32'h1000);
      chk("t1_req_id", ic_req_id, 0);
      tick();
      l = mkline(32'h5555_0000);
      l[2*32 +: 32] = 32'hDEADBEEF;
      ic_rsp_valid = 1'b1;
      ic_rsp_id    = 2'd0;
      ic_rsp_data  = l;
      #1;
      chk("t1_fe_not_yet", fe_rsp_valid, 0);
      tick();
      ic_rsp_valid = 1'b0;
      #1;
      chk("t1_fe_valid", fe_rsp_valid, 1);
      chk("t1_fe_pc", fe_rsp_pc, 32'h1008);
      chk("t1_fe_instr", fe_rsp_instr, 32'hDEADBEEF);
      chk("t1_occ1", occupancy, 1);
      fe_rsp_ready = 1'b1;
      tick();
      fe_rsp_ready = 1'b0;
      #1;
      chk("t1_occ0", occupancy, 0);
      chk("t1_fe_done", fe_rsp_valid, 0);

      // out-of-order responses, in-order FE return, FE stall
      do_reset();
      ic_req_ready = 1'b1;
      push(32'h100, 1'b0);
      push(32'h204, 1'b0);
      push(32'h308, 1'b0);
      tick();
      ic_req_ready = 1'b0;
      #1;
      chk("t2_occ3", occupancy, 3);
      chk("t2_all_granted", ic_req_valid, 0);
      send(2, mkline(32'hCCCC_0000));
      #1;
      chk("t2_no_bypass_c", fe_rsp_valid, 0);
      send(1, mkline(32'hBBBB_0000));
      #1;
      chk("t2_no_bypass_b", fe_rsp_valid, 0);
      send(0, mkline(32'hAAAA_0000));
      #1;
      chk("t2_a_valid", fe_rsp_valid, 1);
      chk("t2_a_pc", fe_rsp_pc, 32'h100);
      chk("t2_a_instr", fe_rsp_instr, 32'hAAAA_0000);
      pc0 = fe_rsp_pc;
      in0 = fe_rsp_instr;
      for (int s = 0; s < 3; s++) begin
         tick();
         #1;
         chk("t2_stall_valid", fe_rsp_valid, 1);
         chk("t2_stall_pc", fe_rsp_pc, {32'h0, pc0});
         chk("t2_stall_instr", fe_rsp_instr, {32'h0, in0});
      end
      fe_rsp_ready = 1'b1;
      tick();
      #1;
      chk("t2_b_pc", fe_rsp_pc, 32'h204);
      chk("t2_b_instr", fe_rsp_instr, 32'hBBBB_0001);
      tick();
      #1;
      chk("t2_c_pc", fe_rsp_pc, 32'h308);
      chk("t2_c_instr", fe_rsp_instr, 32'hCCCC_0002);
      tick();
      fe_rsp_ready = 1'b0;
      #1;
      chk("t2_empty_valid", fe_rsp_valid, 0);
      chk("t2_empty_occ", occupancy, 0);

      // full buffer, round-robin grant order and pointer wrap
      do_reset();
      push(32'h400, 1'b1);
      push(32'h440, 1'b1);
      push(32'h480, 1'b1);
      push(32'h4C0, 1'b1);
      #1;
      chk("t3_occ4", occupancy, 4);
      chk("t3_push_ready0", push_ready, 0);
      ic_req_ready = 1'b1;
      for (int g = 0; g < 4; g++) begin
         #1;
         chk("t3_grant_valid", ic_req_valid, 1);
         chk("t3_grant_id", ic_req_id, 64'(g));
         tick();
      end
      ic_req_ready = 1'b0;
      #1;
      chk("t3_no_req", ic_req_valid, 0);
      send(1, mkline(32'h0));
      send(3, mkline(32'h0));
      push(32'h500, 1'b1);
      push(32'h540, 1'b1);
      #1;
      chk("t3_wrap_id1", ic_req_id, 1);
      chk("t3_wrap_addr", ic_req_addr, 32'h500);
      ic_req_ready = 1'b1;
      tick();
      #1;
      chk("t3_next_id3", ic_req_id, 3);
      tick();
      ic_req_ready = 1'b0;
      for (int g = 0; g < 4; g++) send(g, mkline(32'h0));
      #1;
      chk("t3_drain_occ", occupancy, 0);

      // prefetch retires silently
      do_reset();
      ic_req_ready = 1'b1;
      push(32'h2000, 1'b1);
      #1;
      chk("t4_req_addr", ic_req_addr, 32'h2000);
      tick();
      send(0, mkline(32'h7700_0000));
      #1;
      chk("t4_no_fe", fe_rsp_valid, 0);
      chk("t4_occ0", occupancy, 0);

      // flush: PDG_IC -> FLUSHED, REQ_IC -> IDLE
      do_reset();
      ic_req_ready = 1'b1;
      push(32'h3000, 1'b0);
      push(32'h3040, 1'b0);
      ic_req_ready = 1'b0;
      #1;
      chk("t5_occ2", occupancy, 2);
      chk("t5_req_b", ic_req_id, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("t5_occ1", occupancy, 1);
      chk("t5_b_idle", ic_req_valid, 0);
      chk("t5_push_ready", push_ready, 1);
      send(0, mkline(32'h0));
      #1;
      chk("t5_late_no_fe", fe_rsp_valid, 0);
      chk("t5_late_occ0", occupancy, 0);
      // flush masks a ready demand response
      ic_req_ready = 1'b1;
      push(32'h3100, 1'b0);
      tick();
      ic_req_ready = 1'b0;
      send(0, mkline(32'h0));
      flush = 1'b1;
      #1;
      chk("t5_flush_mask", fe_rsp_valid, 0);
      tick();
      flush = 1'b0;
      #1;
      chk("t5_flush_fe_occ", occupancy, 0);
      // grant in the flush cycle is honoured
      push(32'h3200, 1'b0);
      ic_req_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      ic_req_ready = 1'b0;
      #1;
      chk("t5_gnt_flushed_occ", occupancy, 1);
      chk("t5_gnt_flushed_req", ic_req_valid, 0);
      send(0, mkline(32'h0));
      #1;
      chk("t5_gnt_late_occ", occupancy, 0);

      // asynchronous reset with entries in mixed states
      do_reset();
      ic_req_ready = 1'b1;
      push(32'h6000, 1'b0);
      push(32'h6040, 1'b0);
      push(32'h6080, 1'b0);
      ic_req_ready = 1'b0;
      send(0, mkline(32'h6000_0000));
      #1;
      chk("t6_pre_fe", fe_rsp_valid, 1);
      chk("t6_pre_occ", occupancy, 3);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_push_ready", push_ready, 1);
      chk("t6_req_valid", ic_req_valid, 0);
      chk("t6_fe_valid", fe_rsp_valid, 0);
      chk("t6_occ", occupancy, 0);
      #10;
      reset = 1'b0;
      tick();

      // table-driven address/word-select vectors
      ic_req_ready = 1'b1;
      foreach (tbl[v]) begin
         push(tbl[v].addr, tbl[v].pf);
         #1;
         chk("tbl_req_valid", ic_req_valid, 1);
         chk("tbl_req_addr", ic_req_addr, tbl[v].e_req);
         tick();
         send(0, mkline(32'hA000_0000));
         #1;
         chk("tbl_fe_valid", fe_rsp_valid, tbl[v].e_fv);
         if (tbl[v].e_fv) begin
            chk("tbl_fe_pc", fe_rsp_pc, tbl[v].addr);
            chk("tbl_fe_instr", fe_rsp_instr, tbl[v].e_instr);
         end
         fe_rsp_ready = 1'b1;
         tick();
         fe_rsp_ready = 1'b0;
         #1;
         chk("tbl_occ0", occupancy, 0);
      end

      // randomized run against the reference model
      do_reset();
      for (int i = 0; i < N; i++) begin
         m_used[i] = 0; m_gnt[i] = 0; m_rsp[i] = 0; m_fl[i] = 0;
         m_pf[i] = 0; m_addr[i] = '0; m_instr[i] = '0;
      end
      m_rr = 0;
      dq.delete();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         push_valid   = ($urandom_range(0, 9) < 6);
         push_addr    = $urandom;
         push_pf      = ($urandom_range(0, 3) == 0);
         ic_req_ready = ($urandom_range(0, 9) < 6);
         fe_rsp_ready = ($urandom_range(0, 9) < 7);
         flush        = ($urandom_range(0, 49) == 0);
         pend.delete();
         for (int i = 0; i < N; i++)
            if (m_used[i] && m_gnt[i] && !m_rsp[i]) pend.push_back(i);
         ic_rsp_valid = 1'b0;
         rid = 0;
         if (!flush && pend.size() > 0 && $urandom_range(0, 1) == 1) begin
            rid = pend[$urandom_range(0, pend.size()-1)];
            for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
            ic_rsp_valid = 1'b1;
            ic_rsp_id    = 2'(rid);
            ic_rsp_data  = l;
         end
         #1;
         e_pr = 0;
         e_occ = 0;
         e_alloc = -1;
         for (int i = 0; i < N; i++) begin
            if (!m_used[i]) begin
               e_pr = 1;
               if (e_alloc < 0) e_alloc = i;
            end else e_occ++;
         end
         e_rv = 0;
         e_rid = 0;
         for (int k = 0; k < N; k++) begin
            int ix;
            ix = (m_rr + k) % N;
            if (!e_rv && m_used[ix] && !m_gnt[ix]) begin
               e_rv = 1;
               e_rid = ix;
            end
         end
         e_fv = (dq.size() > 0) && m_rsp[dq[0]] && !flush;
         chk("rnd_push_ready", push_ready, e_pr);
         chk("rnd_occ", occupancy, 64'(e_occ));
         chk("rnd_req_valid", ic_req_valid, e_rv);
         if (e_rv) begin
            chk("rnd_req_id", ic_req_id, 64'(e_rid));
            chk("rnd_req_addr", ic_req_addr, m_addr[e_rid] & 32'hFFFF_FFC0);
         end
         chk("rnd_fe_valid", fe_rsp_valid, e_fv);
         if (e_fv) begin
            chk("rnd_fe_pc", fe_rsp_pc, m_addr[dq[0]]);
            chk("rnd_fe_instr", fe_rsp_instr, m_instr[dq[0]]);
         end
         if (e_rv && ic_req_ready) begin
            m_gnt[e_rid] = 1;
            m_rr = (e_rid + 1) % N;
         end
         if (ic_rsp_valid) begin
            if (m_fl[rid] || m_pf[rid]) m_used[rid] = 0;
            else begin
               m_rsp[rid] = 1;
               m_instr[rid] = l[((m_addr[rid] >> 2) & 32'hF)*32 +: 32];
            end
         end
         if (e_fv && fe_rsp_ready) begin
            m_used[dq[0]] = 0;
            void'(dq.pop_front());
         end
         if (flush) begin
            for (int i = 0; i < N; i++) begin
               if (m_used[i]) begin
                  if (m_gnt[i] && !m_rsp[i]) m_fl[i] = 1;
                  else m_used[i] = 0;
               end
            end
            dq.delete();
         end else if (push_valid && e_pr) begin
            m_used[e_alloc] = 1;
            m_gnt[e_alloc]  = 0;
            m_rsp[e_alloc]  = 0;
            m_fl[e_alloc]   = 0;
            m_pf[e_alloc]   = push_pf;
            m_addr[e_alloc] = push_addr;
            if (!push_pf) dq.push_back(e_alloc);
         end
      end
      @(negedge clk);
      idle_in();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
